// File: rtl/ff_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ff_seq_pkg
//  Description : Shared types and helpers for feed_forward_layer_sequencer.
//                Holds the sequencer state encoding and the address-width
//                helpers used to size the RAM and output-buffer ports.
//  Revision    : 1.0 - initial release
// ============================================================================
package ff_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  // Address width for a memory of the given depth, never narrower than 1 bit.
  function automatic int addr_width(input int depth);
    if (depth <= 1) return 1;
    return $clog2(depth);
  endfunction

  function automatic int in_addr_width(input int n);
    return addr_width(n);
  endfunction

  function automatic int w_addr_width(input int n, input int m);
    return addr_width(n * m);
  endfunction

  function automatic int out_addr_width(input int m);
    return addr_width(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/feed_forward_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : feed_forward_layer_sequencer
//  Description : Runs one fully-connected layer through a shared serial
//                node. For each output neuron j it streams N (weight, data)
//                pairs read from synchronous RAMs (latency 1), waits for the
//                node result and writes it to the output buffer at j.
//  Ports       : clk, rst_n          - clock, synchronous active-low reset
//                i_start             - start pulse (accepted only when idle)
//                o_busy/o_done       - run in progress / end-of-run pulse
//                o_error             - sticky: node result arrived mid-feed
//                o_rd_en, o_*_addr   - RAM read strobe and addresses
//                i_*_rdata           - RAM read data
//                o_node_*            - pair stream to the node
//                i_node_valid/data   - node result
//                o_out_wr_en/addr/data - output-buffer write port
//  Revision    : 1.0 - initial release
// ============================================================================
module feed_forward_layer_sequencer
  import ff_seq_pkg::*;
#(
  parameter int DATA_WIDTH            = 32,
  parameter int NUMBER_OF_INPUT_NODE  = 3,
  parameter int NUMBER_OF_OUTPUT_NODE = 32,
  localparam int IN_ADDR_W  = in_addr_width(NUMBER_OF_INPUT_NODE),
  localparam int W_ADDR_W   = w_addr_width(NUMBER_OF_INPUT_NODE, NUMBER_OF_OUTPUT_NODE),
  localparam int OUT_ADDR_W = out_addr_width(NUMBER_OF_OUTPUT_NODE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic                  o_rd_en,
  output logic [IN_ADDR_W-1:0]  o_data_addr,
  output logic [W_ADDR_W-1:0]   o_weight_addr,
  input  logic [DATA_WIDTH-1:0] i_data_rdata,
  input  logic [DATA_WIDTH-1:0] i_weight_rdata,
  output logic                  o_node_valid,
  output logic [DATA_WIDTH-1:0] o_node_data,
  output logic [DATA_WIDTH-1:0] o_node_weight,
  input  logic                  i_node_valid,
  input  logic [DATA_WIDTH-1:0] i_node_data,
  output logic                  o_out_wr_en,
  output logic [OUT_ADDR_W-1:0] o_out_addr,
  output logic [DATA_WIDTH-1:0] o_out_data
);

  localparam logic [IN_ADDR_W-1:0]  LAST_I = IN_ADDR_W'(NUMBER_OF_INPUT_NODE - 1);
  localparam logic [OUT_ADDR_W-1:0] LAST_J = OUT_ADDR_W'(NUMBER_OF_OUTPUT_NODE - 1);

  seq_state_t            state, state_d;
  logic [IN_ADDR_W-1:0]  i_d;
  logic [W_ADDR_W-1:0]   waddr_d;
  logic [OUT_ADDR_W-1:0] j_cnt, j_d;
  logic                  error_d;
  logic                  wr_d;
  logic [OUT_ADDR_W-1:0] out_addr_d;
  logic [DATA_WIDTH-1:0] out_data_d;

  // The address outputs are the i / weight counters themselves, so in FEED
  // they are valid in the same cycles as the read strobe.
  assign o_rd_en       = (state == FEED);
  // o_done is registered one cycle after DONE while the state is already
  // IDLE; busy covers that cycle so the run is reported complete only after
  // the done pulse has been seen.
  assign o_busy        = (state != IDLE) || o_done;
  assign o_node_data   = i_data_rdata;
  assign o_node_weight = i_weight_rdata;

  always_comb begin
    state_d    = state;
    i_d        = o_data_addr;
    waddr_d    = o_weight_addr;
    j_d        = j_cnt;
    error_d    = o_error;
    wr_d       = 1'b0;
    out_addr_d = o_out_addr;
    out_data_d = o_out_data;
    unique case (state)
      IDLE: begin
        // A start coinciding with the trailing done pulse is treated as
        // arriving while busy and is dropped.
        if (i_start && !o_done) begin
          state_d = FEED;
          i_d     = '0;
          j_d     = '0;
          waddr_d = '0;
          error_d = 1'b0;
        end
      end
      FEED: begin
        // The weight address runs continuously across neurons, so after the
        // last pair of neuron j it already points at (j+1)*N.
        waddr_d = o_weight_addr + 1'b1;
        if (o_data_addr == LAST_I) begin
          i_d     = '0;
          state_d = WAIT;
        end else begin
          i_d = o_data_addr + 1'b1;
        end
        if (i_node_valid) error_d = 1'b1;
      end
      WAIT: begin
        if (i_node_valid) begin
          wr_d       = 1'b1;
          out_addr_d = j_cnt;
          out_data_d = i_node_data;
          if (j_cnt == LAST_J) begin
            state_d = DONE;
          end else begin
            j_d     = j_cnt + 1'b1;
            state_d = FEED;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      o_data_addr   <= '0;
      o_weight_addr <= '0;
      j_cnt         <= '0;
      o_error       <= 1'b0;
      o_done        <= 1'b0;
      o_node_valid  <= 1'b0;
      o_out_wr_en   <= 1'b0;
      o_out_addr    <= '0;
      o_out_data    <= '0;
    end else begin
      state         <= state_d;
      o_data_addr   <= i_d;
      o_weight_addr <= waddr_d;
      j_cnt         <= j_d;
      o_error       <= error_d;
      o_done        <= (state == DONE);
      // RAM read latency is one cycle; delaying the strobe aligns the valid
      // with the returned pair.
      o_node_valid  <= o_rd_en;
      o_out_wr_en   <= wr_d;
      o_out_addr    <= out_addr_d;
      o_out_data    <= out_data_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/feed_forward_layer_sequencer.md
# feed_forward_layer_sequencer

Controller that runs one fully-connected layer through the shared serial `feed_forward_layer` datapath. On `i_start` it reads the input vector and weight matrix from external synchronous RAMs. It streams one (weight, data) pair per cycle into the node for each output neuron, then collects each node result and writes it to the output buffer. It sits between the layer's weight/activation memories and the `feed_forward_layer` instance. The DQN top-level FSM starts it once per layer.

## Interface
- `DATA_WIDTH`, 32: width of weights, activations and results (IEEE-754 single).
- `NUMBER_OF_INPUT_NODE`, 3: N, pairs per output neuron; must be ≥ 1.
- `NUMBER_OF_OUTPUT_NODE`, 32: M, output neurons per layer run; must be ≥ 1.
- Derived localparams:
  - `IN_ADDR_W = max(1, clog2(N))`
  - `W_ADDR_W = max(1, clog2(N*M))`
  - `OUT_ADDR_W = max(1, clog2(M))`

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `i_start` in 1: start pulse; sampled only in IDLE.
- `o_busy` out 1: high whenever state ≠ IDLE.
- `o_done` out 1: one-cycle pulse after the last result is written.
- `o_error` out 1: sticky protocol-error flag; cleared on accepted start.
- `o_rd_en` out 1: read strobe to both RAMs (read latency exactly 1 cycle).
- `o_data_addr` out IN_ADDR_W: input-vector address i.
- `o_weight_addr` out W_ADDR_W: weight address j*N+i.
- `i_data_rdata` in DATA_WIDTH: input RAM read data.
- `i_weight_rdata` in DATA_WIDTH: weight RAM read data.
- `o_node_valid` out 1: to node `i_valid`.
- `o_node_data` out DATA_WIDTH: to node `i_data`; combinational from `i_data_rdata`.
- `o_node_weight` out DATA_WIDTH: to node `i_weight`; combinational from `i_weight_rdata`.
- `i_node_valid` in 1: from node `o_valid`.
- `i_node_data` in DATA_WIDTH: from node `o_data`.
- `o_out_wr_en` out 1: output-buffer write strobe.
- `o_out_addr` out OUT_ADDR_W: output neuron index j.
- `o_out_data` out DATA_WIDTH: result for neuron j.

## Operation
- States: IDLE, FEED, WAIT, DONE.
- **IDLE**
  - `i_start`=1 → FEED with i=0, j=0, and `o_error` cleared.
  - `i_node_valid` ignored.
- **FEED**
  - Each cycle: `o_rd_en`=1, `o_data_addr`=i, `o_weight_addr`=j*N+i. The weight address is a running counter that increments by 1; no multiplier.
  - i increments each cycle. At i=N-1 → WAIT and i resets to 0.
  - `i_node_valid`=1 in FEED sets `o_error`, and the result is discarded.
- **WAIT**
  - `o_rd_en`=0. Hold until `i_node_valid`=1.
  - On that cycle, register `o_out_wr_en`=1, `o_out_addr`=j, `o_out_data`=`i_node_data`.
  - If j=M-1 → DONE; otherwise j increments → FEED.
- **DONE**: `o_done`=1 for one cycle → IDLE.
- `o_node_valid` is `o_rd_en` delayed one cycle (registered), aligned with RAM read data.
- `i_start` while busy is ignored and has no effect on counters.
- No timeout: WAIT holds indefinitely. Only reset aborts.

## Timing
- Reset (rst_n=0 at an edge):
  - state=IDLE; i=j=0.
  - `o_busy`, `o_done`, `o_error`, `o_rd_en`, `o_node_valid`, `o_out_wr_en` = 0.
  - `o_data_addr`, `o_weight_addr`, `o_out_addr`, `o_out_data` = 0.
  - Reset mid-run aborts immediately; no partial write or `o_done` follows.
- Start sampled at edge 0 → FEED registered outputs valid in cycles 1..N.
- `o_node_valid` is high in cycles 2..N+1 with pairs i=0..N-1 in order.
- Writes:
  - `i_node_valid` sampled at edge k → `o_out_wr_en` high in cycle k+1.
  - In the same cycle k+1, the next neuron's FEED begins, so there is no bubble between neurons beyond node latency.
- Last neuron: write in cycle k+1, `o_done` in cycle k+2, `o_busy` low from cycle k+3.
- A node result arriving in the same cycle the sequencer enters WAIT (first WAIT cycle) is accepted.

## Structure
- Package `ff_seq_pkg`: state enum (IDLE, FEED, WAIT, DONE) and the clog2-based address-width functions.
- Single module, no sub-module; the i, j and weight-address counters are inline.
- The bench instantiates the sequencer together with `feed_forward_layer` and behavioural RAM models.

## Test plan
- **Single run, N=3, M=4**, weights 1.0, inputs {1.0, 2.0, 3.0}:
  - four writes at addresses 0..3 with data 32'h40C00000 (6.0);
  - `o_done` exactly once; `o_weight_addr` sequence 0..11.
- **Degenerate N=1, M=1**: one read, one write at address 0, `o_done` two cycles after `i_node_valid`.
- **Start while busy**: second `i_start` pulse mid-FEED → no restart, address sequence unchanged, `o_done` once.
- **Reset mid-WAIT**: `rst_n`=0 for one cycle at j=2 → all outputs 0 next cycle, no write for j=2, IDLE. A subsequent start runs cleanly from j=0.
- **Spurious `i_node_valid`** injected in FEED → `o_error`=1, no write. Cleared by the next accepted `i_start`.
- **Stalled node**: `i_node_valid` delayed 50 cycles → `o_busy` held, `o_rd_en`=0 throughout WAIT, correct write on arrival.
